// File: rtl/decoder_req_sched_if.sv
// Request, decoder and response signals of the decoder request scheduler.
// The scheduler uses the slave modport; the environment uses the master modport.
interface decoder_req_sched_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 8
);
  logic             req0_valid;
  logic [IN_W-1:0]  req0_code;
  logic             req0_ready;
  logic             req1_valid;
  logic [IN_W-1:0]  req1_code;
  logic             req1_ready;
  logic [IN_W-1:0]  dec_in;
  logic [OUT_W-1:0] dec_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [OUT_W-1:0] rsp_data;
  logic             busy;
  logic [7:0]       done_cnt;

  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code, dec_out, rsp_ready,
    output req0_ready, req1_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy, done_cnt
  );

  modport master (
    output req0_valid, req0_code, req1_valid, req1_code, dec_out, rsp_ready,
    input  req0_ready, req1_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy, done_cnt
  );
endinterface

// File: rtl/decoder_req_sched.sv
// Round-robin scheduler for two requesters sharing one combinational decoder:
// holds the granted code on dec_in for SETTLE cycles, then returns the result.
module decoder_req_sched #(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2
) (
  input logic                clock,
  input logic                reset,
  decoder_req_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t           state_reg;
  logic             last_grant_reg;
  logic [3:0]       settle_cnt_reg;
  logic [IN_W-1:0]  dec_in_reg;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [OUT_W-1:0] rsp_data_reg;
  logic             busy_reg;
  logic [7:0]       done_cnt_reg;

  logic             idle;
  logic             grant0;
  logic             grant1;
  logic [IN_W-1:0]  accept_code;

  // On a tie the requester that did not win last time is granted.
  assign idle        = (state_reg == IDLE);
  assign grant0      = idle && bus.req0_valid && (!bus.req1_valid || last_grant_reg);
  assign grant1      = idle && bus.req1_valid && (!bus.req0_valid || !last_grant_reg);
  assign accept_code = grant1 ? bus.req1_code : bus.req0_code;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.dec_in     = dec_in_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.busy       = busy_reg;
  assign bus.done_cnt   = done_cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      settle_cnt_reg <= '0;
      dec_in_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_data_reg   <= '0;
      busy_reg       <= 1'b0;
      done_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            dec_in_reg     <= accept_code;
            rsp_id_reg     <= grant1;
            last_grant_reg <= grant1;
            settle_cnt_reg <= SETTLE_INIT;
            busy_reg       <= 1'b1;
            state_reg      <= DRIVE;
          end
        end
        DRIVE: begin
          // dec_in stays frozen here so the decoder output can settle.
          if (settle_cnt_reg != 4'd0) begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end else begin
            rsp_data_reg  <= bus.dec_out;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            done_cnt_reg  <= done_cnt_reg + 8'd1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/decoder_req_sched.md
# decoder_req_sched

Request scheduler sitting in front of the shared `decoder_proj` combinational decoder. Two requesters present 7-bit codes through valid/ready handshakes; the block arbitrates round-robin and drives the winning code onto the decoder input. It holds the code for a programmable settle time, captures the decoder output, and returns it tagged with the requester ID through a valid/ready response channel. It is the only driver of the decoder's `io_in` bus.

## Interface
- `IN_W`, 7: code width; matches decoder `io_in`.
- `OUT_W`, 8: decoder output width.
- `SETTLE`, 2: cycles the code is held on `dec_in` before capture; legal range 1..15.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req0_valid` input 1: requester 0 has a code.
- `req0_code` input IN_W: requester 0 code.
- `req0_ready` output 1: requester 0 code accepted this cycle.
- `req1_valid`, `req1_code`, `req1_ready`: same for requester 1.
- `dec_in` output IN_W: registered code to the decoder `io_in`.
- `dec_out` input OUT_W: decoder result, combinational from `dec_in`.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_id` output 1: requester that owns the response.
- `rsp_data` output OUT_W: captured decoder result.
- `busy` output 1: high in any state other than IDLE.
- `done_cnt` output 8: completed-response count; wraps.

## Operation
- FSM states are IDLE, DRIVE and RESP.
- IDLE:
  - If exactly one `reqN_valid` is high, grant that requester.
  - If both are high, grant the one not in `last_grant`.
  - `reqN_ready` is combinational and high only for the granted requester, only in IDLE.
  - A handshake is valid + ready in the same cycle. On it:
    - `dec_in` <= code.
    - `rsp_id` <= N.
    - `last_grant` <= N.
    - `settle_cnt` <= SETTLE-1.
    - Go to DRIVE.
- DRIVE:
  - `dec_in` is frozen.
  - If `settle_cnt` != 0, decrement it.
  - If `settle_cnt` == 0: `rsp_data` <= `dec_out`, `rsp_valid` <= 1, go to RESP.
- RESP:
  - `rsp_valid`, `rsp_id` and `rsp_data` are stable until `rsp_valid` and `rsp_ready` are both high.
  - On that handshake: `rsp_valid` <= 0, `done_cnt` <= `done_cnt`+1 (mod 256), go to IDLE.
- No new request is accepted in DRIVE or RESP. One transaction is outstanding at most.
- `dec_in` keeps the last code after completion. It changes only on an accept.
- A requester that drops `valid` before being granted is simply not served. No state is kept for it.
- `reqN_code` is sampled only in the accept cycle.

## Timing
- Reset values:
  - `dec_in`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `done_cnt`=0, `busy`=0, both `reqN_ready`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - State is IDLE.
- Accept at edge T:
  - `dec_in` is new from T.
  - Capture happens at edge T+SETTLE.
  - `rsp_valid` is high from T+SETTLE.
  - With `rsp_ready` tied high, the next accept is possible at edge T+SETTLE+2. Throughput is one code per SETTLE+2 cycles.
- SETTLE=1 captures on the first DRIVE edge.
- `busy` is registered with the state. It is high from the accept edge until the response-handshake edge.
- Reset asserted in any state:
  - Immediate return to IDLE with reset values.
  - An in-flight code is dropped and no response is produced.
  - `done_cnt` is cleared.
- `done_cnt` wraps 255 -> 0 with no flag.

## Test plan
- **Single request:** `req0_code`=7'b1001000 with `req0_valid` held, SETTLE=2, `rsp_ready`=1.
  - `req0_ready` pulses once.
  - `dec_in`=7'b1001000 one edge later.
  - `rsp_valid` high 2 cycles after accept, with `rsp_id`=0 and `rsp_data` equal to the decoder value for 7'b1001000.
  - `done_cnt`=1.
- **Tie arbitration:** both valids held high with codes 7'h11 and 7'h22.
  - Grants alternate 0,1,0,1.
  - Responses carry ids 0,1,0,1 with matching data.
  - Exactly one ready per IDLE cycle.
- **Backpressure:** `rsp_ready`=0 for 10 cycles after `rsp_valid` rises.
  - `rsp_valid`, `rsp_data`, `rsp_id` and `dec_in` stay constant.
  - Both readys stay 0.
  - Completion occurs on the first cycle `rsp_ready`=1.
- **Reset mid-DRIVE:** SETTLE=4, assert `reset` 2 cycles after accept.
  - All outputs return to reset values asynchronously.
  - No response is emitted.
  - After release, the first tie goes to requester 0.
- **Settle sweep:** SETTLE=1 and SETTLE=15.
  - Accept-to-`rsp_valid` latency is exactly 1 and 15 cycles.
  - Captured data equals `dec_out` at the capture edge.
- **Counter wrap:** 256 back-to-back transactions.
  - `done_cnt` returns to 0.
  - No lost or duplicated responses.
